// File: rtl/ex_issue_scoreboard.sv
// Execute-stage issue controller: tracks in-flight scalar, vector and CC writes
// and decides per cycle whether the decode instruction issues, stalls or is squashed.
module ex_issue_scoreboard #(
  parameter int unsigned NUM_REGS      = 16,
  parameter int unsigned NUM_VREGS     = 64,
  parameter int unsigned CC_CNT_MAX    = 3,
  parameter int unsigned FLUSH_DEPTH   = 2,
  localparam int unsigned REG_ID_WIDTH  = $clog2(NUM_REGS),
  localparam int unsigned VREG_ID_WIDTH = $clog2(NUM_VREGS),
  localparam int unsigned CC_WIDTH      = $clog2(CC_CNT_MAX + 1),
  localparam int unsigned FLUSH_WIDTH   = $clog2(FLUSH_DEPTH + 1),
  localparam int unsigned PCNT_WIDTH    = $clog2(NUM_REGS + 1)
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic                     I_DE_Valid,
  input  logic [REG_ID_WIDTH-1:0]  I_Src1Idx,
  input  logic [REG_ID_WIDTH-1:0]  I_Src2Idx,
  input  logic                     I_Src1Use,
  input  logic                     I_Src2Use,
  input  logic [VREG_ID_WIDTH-1:0] I_VSrc1Idx,
  input  logic [VREG_ID_WIDTH-1:0] I_VSrc2Idx,
  input  logic                     I_VSrc1Use,
  input  logic                     I_VSrc2Use,
  input  logic [REG_ID_WIDTH-1:0]  I_DestRegIdx,
  input  logic                     I_RegWEn,
  input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
  input  logic                     I_VRegWEn,
  input  logic                     I_CCWEn,
  input  logic                     I_CCUse,
  input  logic                     I_GPUStallSignal,
  input  logic                     I_BranchTaken,
  input  logic                     I_WB_Valid,
  input  logic                     I_WB_RegWEn,
  input  logic                     I_WB_VRegWEn,
  input  logic                     I_WB_CCWEn,
  input  logic [REG_ID_WIDTH-1:0]  I_WB_DestRegIdx,
  input  logic [VREG_ID_WIDTH-1:0] I_WB_DestVRegIdx,
  output logic                     O_Issue_Signal,
  output logic                     O_Stall_Signal,
  output logic                     O_Kill_Signal,
  output logic                     O_Flush,
  output logic [CC_WIDTH-1:0]      O_CCPending,
  output logic [PCNT_WIDTH-1:0]    O_PendingCount
);

  logic [NUM_REGS-1:0]    pend_q, pend_d;
  logic [NUM_VREGS-1:0]   vpend_q, vpend_d;
  logic [CC_WIDTH-1:0]    cc_cnt_q, cc_cnt_d;
  logic [FLUSH_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [PCNT_WIDTH-1:0]  pend_cnt_q, pend_cnt_d;

  logic hazard;
  logic flush_active;
  logic cc_inc;
  logic cc_dec;

  // Hazards look only at registered state; a retiring write unblocks next cycle.
  always_comb begin
    hazard = 1'b0;
    if (I_Src1Use && pend_q[I_Src1Idx])       hazard = 1'b1;
    if (I_Src2Use && pend_q[I_Src2Idx])       hazard = 1'b1;
    if (I_VSrc1Use && vpend_q[I_VSrc1Idx])    hazard = 1'b1;
    if (I_VSrc2Use && vpend_q[I_VSrc2Idx])    hazard = 1'b1;
    if (I_RegWEn && pend_q[I_DestRegIdx])     hazard = 1'b1;
    if (I_VRegWEn && vpend_q[I_DestVRegIdx])  hazard = 1'b1;
    if (I_CCUse && (cc_cnt_q != '0))          hazard = 1'b1;
    if (I_CCWEn && (cc_cnt_q == CC_WIDTH'(CC_CNT_MAX))) hazard = 1'b1;
  end

  assign flush_active   = (flush_cnt_q != '0);
  assign O_Kill_Signal  = I_DE_Valid & flush_active;
  assign O_Issue_Signal = I_LOCK & I_DE_Valid & ~flush_active & ~hazard & ~I_GPUStallSignal;
  assign O_Stall_Signal = I_DE_Valid & ~flush_active & ~O_Issue_Signal;

  assign cc_inc = O_Issue_Signal & I_CCWEn;
  assign cc_dec = I_WB_Valid & I_WB_CCWEn & (cc_cnt_q != '0);

  always_comb begin
    pend_d  = pend_q;
    vpend_d = vpend_q;
    // Clear first so a same-index set from the issuing instruction wins.
    if (I_WB_Valid && I_WB_RegWEn)  pend_d[I_WB_DestRegIdx]   = 1'b0;
    if (I_WB_Valid && I_WB_VRegWEn) vpend_d[I_WB_DestVRegIdx] = 1'b0;
    if (O_Issue_Signal && I_RegWEn)  pend_d[I_DestRegIdx]   = 1'b1;
    if (O_Issue_Signal && I_VRegWEn) vpend_d[I_DestVRegIdx] = 1'b1;
  end

  always_comb begin
    cc_cnt_d = cc_cnt_q;
    if (cc_inc && !cc_dec)      cc_cnt_d = cc_cnt_q + CC_WIDTH'(1);
    else if (cc_dec && !cc_inc) cc_cnt_d = cc_cnt_q - CC_WIDTH'(1);
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (I_LOCK) begin
      if (I_BranchTaken)     flush_cnt_d = FLUSH_WIDTH'(FLUSH_DEPTH);
      else if (flush_active) flush_cnt_d = flush_cnt_q - FLUSH_WIDTH'(1);
    end
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_cnt_d = pend_cnt_d + PCNT_WIDTH'(pend_d[i]);
    end
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      pend_q      <= '0;
      vpend_q     <= '0;
      cc_cnt_q    <= '0;
      flush_cnt_q <= '0;
      pend_cnt_q  <= '0;
    end else begin
      pend_q      <= pend_d;
      vpend_q     <= vpend_d;
      cc_cnt_q    <= cc_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
    end
  end

  assign O_Flush        = flush_active;
  assign O_CCPending    = cc_cnt_q;
  assign O_PendingCount = pend_cnt_q;

endmodule

// File: tb/tb_ex_issue_scoreboard.sv
// Directed bench for ex_issue_scoreboard: expected output vectors are queued as
// stimulus is driven and popped/compared mid-cycle, away from the negedge.
module tb_ex_issue_scoreboard;

  logic       I_CLOCK = 1'b0;
  logic       I_RESET;
  logic       I_LOCK, I_DE_Valid;
  logic [3:0] I_Src1Idx, I_Src2Idx;
  logic       I_Src1Use, I_Src2Use;
  logic [5:0] I_VSrc1Idx, I_VSrc2Idx;
  logic       I_VSrc1Use, I_VSrc2Use;
  logic [3:0] I_DestRegIdx;
  logic       I_RegWEn;
  logic [5:0] I_DestVRegIdx;
  logic       I_VRegWEn, I_CCWEn, I_CCUse, I_GPUStallSignal, I_BranchTaken;
  logic       I_WB_Valid, I_WB_RegWEn, I_WB_VRegWEn, I_WB_CCWEn;
  logic [3:0] I_WB_DestRegIdx;
  logic [5:0] I_WB_DestVRegIdx;
  logic       O_Issue_Signal, O_Stall_Signal, O_Kill_Signal, O_Flush;
  logic [1:0] O_CCPending;
  logic [4:0] O_PendingCount;

  ex_issue_scoreboard dut (
    .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_DE_Valid(I_DE_Valid),
    .I_Src1Idx(I_Src1Idx), .I_Src2Idx(I_Src2Idx), .I_Src1Use(I_Src1Use),
    .I_Src2Use(I_Src2Use), .I_VSrc1Idx(I_VSrc1Idx), .I_VSrc2Idx(I_VSrc2Idx),
    .I_VSrc1Use(I_VSrc1Use), .I_VSrc2Use(I_VSrc2Use), .I_DestRegIdx(I_DestRegIdx),
    .I_RegWEn(I_RegWEn), .I_DestVRegIdx(I_DestVRegIdx), .I_VRegWEn(I_VRegWEn),
    .I_CCWEn(I_CCWEn), .I_CCUse(I_CCUse), .I_GPUStallSignal(I_GPUStallSignal),
    .I_BranchTaken(I_BranchTaken), .I_WB_Valid(I_WB_Valid), .I_WB_RegWEn(I_WB_RegWEn),
    .I_WB_VRegWEn(I_WB_VRegWEn), .I_WB_CCWEn(I_WB_CCWEn),
    .I_WB_DestRegIdx(I_WB_DestRegIdx), .I_WB_DestVRegIdx(I_WB_DestVRegIdx),
    .O_Issue_Signal(O_Issue_Signal), .O_Stall_Signal(O_Stall_Signal),
    .O_Kill_Signal(O_Kill_Signal), .O_Flush(O_Flush), .O_CCPending(O_CCPending),
    .O_PendingCount(O_PendingCount)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  typedef struct {
    string       tag;
    logic [10:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [10:0] obs;

  assign obs = {O_Issue_Signal, O_Stall_Signal, O_Kill_Signal, O_Flush, O_CCPending,
                O_PendingCount};

  task automatic idle();
    I_LOCK = 1'b1; I_DE_Valid = 1'b0;
    I_Src1Idx = '0; I_Src2Idx = '0; I_Src1Use = 1'b0; I_Src2Use = 1'b0;
    I_VSrc1Idx = '0; I_VSrc2Idx = '0; I_VSrc1Use = 1'b0; I_VSrc2Use = 1'b0;
    I_DestRegIdx = '0; I_RegWEn = 1'b0; I_DestVRegIdx = '0; I_VRegWEn = 1'b0;
    I_CCWEn = 1'b0; I_CCUse = 1'b0; I_GPUStallSignal = 1'b0; I_BranchTaken = 1'b0;
    I_WB_Valid = 1'b0; I_WB_RegWEn = 1'b0; I_WB_VRegWEn = 1'b0; I_WB_CCWEn = 1'b0;
    I_WB_DestRegIdx = '0; I_WB_DestVRegIdx = '0;
  endtask

  // Expected {issue, stall, kill, flush, cc_pending, pending_count}.
  task automatic expect_out(input string tag, input bit iss, input bit stl, input bit kil,
                            input bit fl, input int ccp, input int pc);
    exp_t e;
    e.tag = tag;
    e.val = {iss, stl, kil, fl, 2'(ccp), 5'(pc)};
    exp_q.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL empty_queue observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b (iss,stl,kil,fl,cc[2],pc[5])",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cycle_step();
    @(posedge I_CLOCK);
    compare_now();
    @(negedge I_CLOCK);
    #1;
    idle();
  endtask

  initial begin
    I_RESET = 1'b0;
    idle();
    #1 I_RESET = 1'b1;
    #1;
    // Reset state: issue follows LOCK & DE_Valid & ~GPUStall
    I_DE_Valid = 1; I_RegWEn = 1; I_DestRegIdx = 3;
    expect_out("reset", 1, 0, 0, 0, 0, 0); cycle_step();
    I_RESET = 1'b0;

    // RAW scalar
    I_DE_Valid = 1; I_RegWEn = 1; I_DestRegIdx = 3;
    expect_out("add_r3", 1, 0, 0, 0, 0, 0); cycle_step();
    I_DE_Valid = 1; I_Src1Use = 1; I_Src1Idx = 3; I_RegWEn = 1; I_DestRegIdx = 4;
    expect_out("sub_raw_stall", 0, 1, 0, 0, 0, 1); cycle_step();
    I_DE_Valid = 1; I_Src1Use = 1; I_Src1Idx = 3; I_RegWEn = 1; I_DestRegIdx = 4;
    I_WB_Valid = 1; I_WB_RegWEn = 1; I_WB_DestRegIdx = 3;
    expect_out("sub_no_bypass", 0, 1, 0, 0, 0, 1); cycle_step();
    I_DE_Valid = 1; I_Src1Use = 1; I_Src1Idx = 3; I_RegWEn = 1; I_DestRegIdx = 4;
    expect_out("sub_issue", 1, 0, 0, 0, 0, 0); cycle_step();
    I_WB_Valid = 1; I_WB_RegWEn = 1; I_WB_DestRegIdx = 4;
    expect_out("wb_r4", 0, 0, 0, 0, 0, 1); cycle_step();

    // CC hazard
    I_DE_Valid = 1; I_CCWEn = 1; expect_out("cmpi_a", 1, 0, 0, 0, 0, 0); cycle_step();
    I_DE_Valid = 1; I_CCWEn = 1; expect_out("cmpi_b", 1, 0, 0, 0, 1, 0); cycle_step();
    I_DE_Valid = 1; I_CCUse = 1; expect_out("brz_stall2", 0, 1, 0, 0, 2, 0); cycle_step();
    I_DE_Valid = 1; I_CCUse = 1; I_WB_Valid = 1; I_WB_CCWEn = 1;
    expect_out("brz_wb_a", 0, 1, 0, 0, 2, 0); cycle_step();
    I_DE_Valid = 1; I_CCUse = 1; I_WB_Valid = 1; I_WB_CCWEn = 1;
    expect_out("brz_stall1", 0, 1, 0, 0, 1, 0); cycle_step();
    I_DE_Valid = 1; I_CCUse = 1; expect_out("brz_issue", 1, 0, 0, 0, 0, 0); cycle_step();
    for (int i = 0; i < 3; i++) begin
      I_DE_Valid = 1; I_CCWEn = 1; expect_out("cc_fill", 1, 0, 0, 0, i, 0); cycle_step();
    end
    I_DE_Valid = 1; I_CCWEn = 1; expect_out("cc_full_stall", 0, 1, 0, 0, 3, 0); cycle_step();
    for (int i = 3; i > 0; i--) begin
      I_WB_Valid = 1; I_WB_CCWEn = 1; expect_out("cc_drain", 0, 0, 0, 0, i, 0); cycle_step();
    end
    I_WB_Valid = 1; I_WB_CCWEn = 1; expect_out("cc_dec_at0", 0, 0, 0, 0, 0, 0); cycle_step();
    expect_out("cc_no_underflow", 0, 0, 0, 0, 0, 0); cycle_step();

    // Simultaneous set/clear and CC inc/dec
    I_DE_Valid = 1; I_RegWEn = 1; I_DestRegIdx = 5; I_CCWEn = 1;
    expect_out("set_r5", 1, 0, 0, 0, 0, 0); cycle_step();
    I_DE_Valid = 1; I_RegWEn = 1; I_DestRegIdx = 7; I_CCWEn = 1;
    I_WB_Valid = 1; I_WB_RegWEn = 1; I_WB_DestRegIdx = 5; I_WB_CCWEn = 1;
    expect_out("set_r7_clr_r5", 1, 0, 0, 0, 1, 1); cycle_step();
    I_DE_Valid = 1; I_Src1Use = 1; I_Src1Idx = 7;
    I_WB_Valid = 1; I_WB_RegWEn = 1; I_WB_DestRegIdx = 9;
    expect_out("r7_pending_wb_r9", 0, 1, 0, 0, 1, 1); cycle_step();
    I_DE_Valid = 1; I_Src1Use = 1; I_Src1Idx = 5; I_Src2Use = 1; I_Src2Idx = 9;
    expect_out("r5_r9_free", 1, 0, 0, 0, 1, 1); cycle_step();
    I_WB_Valid = 1; I_WB_RegWEn = 1; I_WB_DestRegIdx = 7; I_WB_CCWEn = 1;
    expect_out("wb_r7", 0, 0, 0, 0, 1, 1); cycle_step();

    // Vector WAW / RAW and GPU stall
    I_DE_Valid = 1; I_VRegWEn = 1; I_DestVRegIdx = 40;
    expect_out("vadd_v40", 1, 0, 0, 0, 0, 0); cycle_step();
    I_DE_Valid = 1; I_VRegWEn = 1; I_DestVRegIdx = 40;
    expect_out("vmovi_waw", 0, 1, 0, 0, 0, 0); cycle_step();
    I_DE_Valid = 1; I_VSrc2Use = 1; I_VSrc2Idx = 40;
    I_WB_Valid = 1; I_WB_VRegWEn = 1; I_WB_DestVRegIdx = 40;
    expect_out("vsrc2_raw", 0, 1, 0, 0, 0, 0); cycle_step();
    I_DE_Valid = 1; I_VRegWEn = 1; I_DestVRegIdx = 40;
    expect_out("vmovi_issue", 1, 0, 0, 0, 0, 0); cycle_step();
    I_WB_Valid = 1; I_WB_VRegWEn = 1; I_WB_DestVRegIdx = 40;
    expect_out("wb_v40", 0, 0, 0, 0, 0, 0); cycle_step();
    I_DE_Valid = 1; I_GPUStallSignal = 1;
    expect_out("gpu_stall", 0, 1, 0, 0, 0, 0); cycle_step();
    I_DE_Valid = 1; I_LOCK = 0; expect_out("lock_low", 0, 1, 0, 0, 0, 0); cycle_step();

    // Branch flush
    I_DE_Valid = 1; I_BranchTaken = 1; expect_out("br_taken", 1, 0, 0, 0, 0, 0); cycle_step();
    for (int i = 0; i < 2; i++) begin
      I_DE_Valid = 1; expect_out("flush_kill", 0, 0, 1, 1, 0, 0); cycle_step();
    end
    I_DE_Valid = 1; expect_out("flush_done", 1, 0, 0, 0, 0, 0); cycle_step();
    I_BranchTaken = 1; expect_out("br_taken2", 0, 0, 0, 0, 0, 0); cycle_step();
    for (int i = 0; i < 4; i++) begin
      I_DE_Valid = 1; I_LOCK = (i >= 2);
      expect_out("flush_locked", 0, 0, 1, 1, 0, 0); cycle_step();
    end
    I_DE_Valid = 1; expect_out("flush_done2", 1, 0, 0, 0, 0, 0); cycle_step();
    I_BranchTaken = 1; expect_out("br_taken3", 0, 0, 0, 0, 0, 0); cycle_step();
    I_DE_Valid = 1; I_BranchTaken = 1;
    expect_out("br_reload", 0, 0, 1, 1, 0, 0); cycle_step();
    for (int i = 0; i < 2; i++) begin
      I_DE_Valid = 1; expect_out("flush_reloaded", 0, 0, 1, 1, 0, 0); cycle_step();
    end
    I_DE_Valid = 1; expect_out("flush_done3", 1, 0, 0, 0, 0, 0); cycle_step();

    // Async reset with full scoreboard, cc=2, flush active
    for (int i = 0; i < 16; i++) begin
      I_DE_Valid = 1; I_RegWEn = 1; I_DestRegIdx = 4'(i); I_CCWEn = (i < 2);
      expect_out("fill_regs", 1, 0, 0, 0, (i < 2) ? i : 2, i); cycle_step();
    end
    I_BranchTaken = 1; expect_out("pre_rst_br", 0, 0, 0, 0, 2, 16); cycle_step();
    expect_out("pre_rst_state", 0, 0, 0, 1, 2, 16);
    @(posedge I_CLOCK);
    compare_now();
    #1 I_RESET = 1'b1;
    I_DE_Valid = 1; I_Src1Use = 1; I_Src1Idx = 0;
    #1;
    expect_out("async_rst", 1, 0, 0, 0, 0, 0);
    compare_now();
    @(negedge I_CLOCK);
    #1;
    idle();
    I_RESET = 1'b0;
    I_DE_Valid = 1; I_RegWEn = 1; I_DestRegIdx = 0;
    expect_out("post_rst_issue", 1, 0, 0, 0, 0, 0); cycle_step();
    expect_out("post_rst_set", 0, 0, 0, 0, 0, 1); cycle_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
